wb_gpio_irq: RTL and testbench
==============================

Name: wb_gpio_irq

Overview:
- Parametrised Wishbone classic slave GPIO controller; successor to the fixed 8-bit gpio0 path that drives LEDR.
- Adds per-pin direction, input synchronisation, an atomic toggle register and edge/level interrupt generation with sticky write-1-to-clear status.
- Sits on the SoC Wishbone bus.
  - Pads connect to board LEDs and GPIO headers.
  - irq_o goes to the CPU interrupt input.

Parameters:
- WIDTH, 8: number of GPIO pins, legal range 1..32.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..4.
- RESET_OUT, 0: reset value of the OUT register (WIDTH bits).
- RESET_DIR, 0: reset value of the DIR register (WIDTH bits; 1 = output).

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_adr_i  in  5  byte address; bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- gpio_i  in  WIDTH  pad inputs, asynchronous.
- gpio_o  out  WIDTH  pad output values; equals the OUT register.
- gpio_dir_o  out  WIDTH  pad output enables; equals the DIR register.
- irq_o  out  1  interrupt request, registered, level-high.

Behaviour:
- Reset values:
  - OUT=RESET_OUT, DIR=RESET_DIR.
  - IRQ_EN=0, IRQ_EDGE=0, IRQ_POL=0, STATUS=0.
  - Synchroniser and previous-value registers = 0.
  - wb_ack_o=0, wb_dat_o=0, irq_o=0.
- Reset mid-transaction aborts it: no ack is issued and no register is written.
- Register map (word offsets). Bits at WIDTH and above read 0 and ignore writes.
  - 0x00 IN: read-only; synchronised pad value, valid regardless of DIR.
  - 0x04 OUT: read/write.
  - 0x08 DIR: read/write.
  - 0x0C IRQ_EN: read/write.
  - 0x10 IRQ_EDGE: read/write; 1 = edge, 0 = level.
  - 0x14 IRQ_POL: read/write; 1 = rising/high, 0 = falling/low.
  - 0x18 STATUS: read; write 1 to clear.
  - 0x1C OUT_TGL: write-only; each 1 bit inverts the matching OUT bit. Reads return 0.
- Wishbone handshake:
  - When cyc&stb&!ack, wb_ack_o is asserted on the next edge for exactly one cycle. Every access takes 2 cycles, and a held strobe gets an ack every other cycle.
  - The write takes effect on the same edge that raises ack.
  - wb_dat_o is registered on that edge; it holds 0 when no read is acked.
  - wb_sel_i gates each byte lane on writes, including STATUS clears and OUT_TGL.
- Input path:
  - gpio_i passes through a SYNC_STAGES flop chain to give sync.
  - prev <= sync every cycle.
  - IN reflects a gpio_i change SYNC_STAGES cycles later.
- Status set, per pin i (evaluated every cycle; independent of IRQ_EN):
  - Edge mode, POL=1: set when sync=1 and prev=0.
  - Edge mode, POL=0: set when sync=0 and prev=1.
  - Level mode: set every cycle while sync==POL. A W1C clear is re-set on the next cycle while the level persists.
  - If a set and a W1C clear hit the same bit in the same cycle, set wins.
- irq_o <= |(STATUS & IRQ_EN), one cycle after STATUS updates.
  - Enabling IRQ_EN on an already-set STATUS bit raises irq_o one cycle after the write's ack edge.
- Latency from a gpio_i edge: STATUS at SYNC_STAGES+1 cycles, irq_o at SYNC_STAGES+2 cycles.
- A pin high during reset produces a rising edge SYNC_STAGES+1 cycles after reset deasserts. STATUS records it; software clears STATUS before enabling interrupts.
- Mode changes (IRQ_EDGE/IRQ_POL writes) do not clear STATUS.

Test Plan:
- Reset with RESET_OUT=8'hA5, RESET_DIR=8'hFF -> gpio_o=A5 and gpio_dir_o=FF; reads of 0x00..0x18 return 0 except 0x04=A5 and 0x08=FF; irq_o=0.
- Write 0x04=0x3C with sel=4'b0001, then write 0x1C=0x0F -> gpio_o=0x33; reading 0x1C returns 0. Every access has ack high for exactly one cycle, 1 cycle after stb.
- IRQ_EN=0x01, IRQ_EDGE=0x01, IRQ_POL=0x01; drive gpio_i[0] 0->1 at cycle t:
  - STATUS[0]=1 at t+3 and irq_o=1 at t+4.
  - Write 0x18=0x01 -> irq_o=0 one cycle after the ack edge.
  - A falling edge on the same pin does not set STATUS.
- Level mode on pin 3, POL=0, gpio_i[3]=0 held; write STATUS=0x08 -> the bit reads 1 again on the next read; irq_o stays 1.
  - Release gpio_i[3]=1, then clear -> STATUS reads 0.
- Simultaneous case: arrange a pin-1 rising edge to set STATUS on the same cycle a W1C of 0x02 takes effect -> STATUS[1]=1 afterwards.
- Assert reset while stb is high before ack -> no ack, no write; all outputs return to their reset values immediately (asynchronously).

Source files
------------

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone classic slave GPIO controller.
//
// Per-pin output value and direction, synchronised inputs, an atomic
// toggle register, and edge/level interrupt detection that sets sticky
// write-1-to-clear status bits.
//
// Ports:
//   clock, reset           system clock (rising edge), async active-high reset
//   wb_adr_i[4:0]          byte address, bits [1:0] ignored
//   wb_dat_i / wb_dat_o    write / registered read data (32 bits)
//   wb_sel_i[3:0]          byte lane enables for writes
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o   classic handshake
//   gpio_i                 asynchronous pad inputs
//   gpio_o, gpio_dir_o     pad output values and output enables
//   irq_o                  registered level-high interrupt request
//
// Register map (word offsets): 0x00 IN, 0x04 OUT, 0x08 DIR, 0x0C IRQ_EN,
// 0x10 IRQ_EDGE, 0x14 IRQ_POL, 0x18 STATUS (W1C), 0x1C OUT_TGL (write-only).
module wb_gpio_irq #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    localparam logic [2:0] A_IN     = 3'd0;
    localparam logic [2:0] A_OUT    = 3'd1;
    localparam logic [2:0] A_DIR    = 3'd2;
    localparam logic [2:0] A_EN     = 3'd3;
    localparam logic [2:0] A_EDGE   = 3'd4;
    localparam logic [2:0] A_POL    = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;
    localparam logic [2:0] A_TGL    = 3'd7;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] level_ev;
    logic [WIDTH-1:0] set_ev;
    logic [31:0]      rdata;
    logic             req;

    logic unused_ok;
    assign unused_ok = ^{wb_adr_i[1:0], wb_dat_i, wb_sel_i};

    assign sync = sync_q[SYNC_STAGES-1];
    assign req  = wb_cyc_i & wb_stb_i & ~ack_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        assign wmask[g] = wb_sel_i[g/8];
    end

    // Only bits in enabled byte lanes count as written.
    assign wdata = wb_dat_i[WIDTH-1:0] & wmask;

    assign edge_ev  = (pol_q & sync & ~prev_q) | (~pol_q & ~sync & prev_q);
    assign level_ev = ~(sync ^ pol_q);
    assign set_ev   = (edge_q & edge_ev) | (~edge_q & level_ev);

    always_comb begin
        rdata = '0;
        case (wb_adr_i[4:2])
            A_IN:     rdata[WIDTH-1:0] = sync;
            A_OUT:    rdata[WIDTH-1:0] = out_q;
            A_DIR:    rdata[WIDTH-1:0] = dir_q;
            A_EN:     rdata[WIDTH-1:0] = en_q;
            A_EDGE:   rdata[WIDTH-1:0] = edge_q;
            A_POL:    rdata[WIDTH-1:0] = pol_q;
            A_STATUS: rdata[WIDTH-1:0] = status_q;
            default:  rdata = '0;
        endcase
    end

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        en_d     = en_q;
        edge_d   = edge_q;
        pol_d    = pol_q;
        status_d = status_q;
        if (req && wb_we_i) begin
            case (wb_adr_i[4:2])
                A_OUT:    out_d    = (out_q & ~wmask) | wdata;
                A_DIR:    dir_d    = (dir_q & ~wmask) | wdata;
                A_EN:     en_d     = (en_q & ~wmask) | wdata;
                A_EDGE:   edge_d   = (edge_q & ~wmask) | wdata;
                A_POL:    pol_d    = (pol_q & ~wmask) | wdata;
                A_STATUS: status_d = status_q & ~wdata;
                A_TGL:    out_d    = out_q ^ wdata;
                default:  ;
            endcase
        end
        // A new event in the same cycle as a clear must survive.
        status_d = status_d | set_ev;
        ack_d    = req;
        dat_d    = (req && !wb_we_i) ? rdata : 32'd0;
        irq_d    = |(status_q & en_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            prev_q   <= '0;
            out_q    <= RESET_OUT;
            dir_q    <= RESET_DIR;
            en_q     <= '0;
            edge_q   <= '0;
            pol_q    <= '0;
            status_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            prev_q   <= sync;
            out_q    <= out_d;
            dir_q    <= dir_d;
            en_q     <= en_d;
            edge_q   <= edge_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign gpio_o     = out_q;
    assign gpio_dir_o = dir_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
module tb_wb_gpio_irq;

    localparam int W  = 8;
    localparam int SS = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic [W-1:0] gpio_i = '0;
    logic [W-1:0] gpio_o;
    logic [W-1:0] gpio_dir_o;
    logic        irq_o;

    always #5 clock = ~clock;

    wb_gpio_irq #(
        .WIDTH(W), .SYNC_STAGES(SS), .RESET_OUT(8'hA5), .RESET_DIR(8'hFF)
    ) dut (
        .clock(clock), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_dir_o(gpio_dir_o), .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register contents, pad history, and bus state.
    logic [W-1:0] m_out, m_dir, m_en, m_edge, m_pol, m_status;
    logic         m_irq, m_ack;
    logic [31:0]  m_dat;
    logic [W-1:0] hist [SS+1];   // hist[k] = gpio_i seen k+1 edges ago

    task automatic model_reset();
        m_out = 8'hA5; m_dir = 8'hFF;
        m_en = '0; m_edge = '0; m_pol = '0; m_status = '0;
        m_irq = 1'b0; m_ack = 1'b0; m_dat = '0;
        for (int k = 0; k <= SS; k++) hist[k] = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [W-1:0] v;
        case (a[4:2])
            3'd0: v = hist[SS-1];
            3'd1: v = m_out;
            3'd2: v = m_dir;
            3'd3: v = m_en;
            3'd4: v = m_edge;
            3'd5: v = m_pol;
            3'd6: v = m_status;
            default: v = '0;
        endcase
        return 32'(v);
    endfunction

    // Advance the model across the coming clock edge using current inputs.
    task automatic model_step();
        logic [W-1:0] sync, prev, setv, n_status;
        logic         req, n_irq;
        logic [31:0]  n_dat;
        sync = hist[SS-1];
        prev = hist[SS];
        setv = '0;
        for (int i = 0; i < W; i++) begin
            if (m_edge[i])
                setv[i] = m_pol[i] ? (sync[i] && !prev[i]) : (!sync[i] && prev[i]);
            else
                setv[i] = (sync[i] == m_pol[i]);
        end
        req      = wb_cyc_i && wb_stb_i && !m_ack;
        n_irq    = |(m_status & m_en);
        n_dat    = '0;
        n_status = m_status;
        if (req && !wb_we_i) n_dat = model_read(wb_adr_i);
        if (req && wb_we_i) begin
            for (int i = 0; i < W; i++) begin
                if (wb_sel_i[i/8]) begin
                    case (wb_adr_i[4:2])
                        3'd1: m_out[i]  = wb_dat_i[i];
                        3'd2: m_dir[i]  = wb_dat_i[i];
                        3'd3: m_en[i]   = wb_dat_i[i];
                        3'd4: m_edge[i] = wb_dat_i[i];
                        3'd5: m_pol[i]  = wb_dat_i[i];
                        3'd6: if (wb_dat_i[i]) n_status[i] = 1'b0;
                        3'd7: if (wb_dat_i[i]) m_out[i] = ~m_out[i];
                        default: ;
                    endcase
                end
            end
        end
        m_status = n_status | setv;
        m_irq    = n_irq;
        m_dat    = n_dat;
        m_ack    = req;
        for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = gpio_i;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("gpio_o", 32'(gpio_o), 32'(m_out));
        check("gpio_dir_o", 32'(gpio_dir_o), 32'(m_dir));
        check("irq_o", 32'(irq_o), 32'(m_irq));
        check("wb_ack_o", 32'(wb_ack_o), 32'(m_ack));
        check("wb_dat_o", wb_dat_o, m_dat);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        tick();
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        wb_adr_i = a; wb_sel_i = 4'hF;
        wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        tick();
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  addrs [7];
        logic [31:0] rexp  [7];
        addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C};
        rexp  = '{32'h00, 32'hA5, 32'hFF, 32'h00, 32'h00, 32'h00, 32'h00};

        repeat (3) @(posedge clock);
        #1;
        check("rst_gpio_o", 32'(gpio_o), 32'hA5);
        check("rst_dir", 32'(gpio_dir_o), 32'hFF);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_ack", 32'(wb_ack_o), 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        reset = 1'b0;
        model_reset();

        // STATUS first: level-low detection starts setting bits right after reset.
        bus_read(5'h18, rd);
        check("rst_rd_status", rd, 32'h0);
        for (int i = 0; i < 7; i++) begin
            bus_read(addrs[i], rd);
            check("rst_rd", rd, rexp[i]);
        end

        bus_write(5'h04, 32'h0000_003C, 4'b0001);
        check("out_write", 32'(gpio_o), 32'h3C);
        bus_write(5'h1C, 32'h0000_000F, 4'hF);
        check("out_tgl", 32'(gpio_o), 32'h33);
        bus_read(5'h1C, rd);
        check("tgl_read", rd, 32'h0);
        bus_write(5'h04, 32'hFFFF_FF00, 4'b1110);
        check("sel_gated", 32'(gpio_o), 32'h33);

        // Rising-edge interrupt on pin 0.
        bus_write(5'h10, 32'h01, 4'hF);
        bus_write(5'h14, 32'h01, 4'hF);
        bus_write(5'h18, 32'hFF, 4'hF);
        bus_write(5'h0C, 32'h01, 4'hF);
        gpio_i[0] = 1'b1;
        tick();
        check("edge_t1_irq", 32'(irq_o), 32'h0);
        tick();
        tick();
        check("edge_t3_irq", 32'(irq_o), 32'h0);
        bus_read(5'h18, rd);
        check("edge_status", rd & 32'h1, 32'h1);
        check("edge_irq", 32'(irq_o), 32'h1);
        bus_write(5'h18, 32'h01, 4'hF);
        check("w1c_irq", 32'(irq_o), 32'h0);
        gpio_i[0] = 1'b0;
        repeat (6) tick();
        bus_read(5'h18, rd);
        check("fall_no_set", rd & 32'h1, 32'h0);

        // Level-low on pin 3: a clear does not stick while the level persists.
        bus_write(5'h0C, 32'h08, 4'hF);
        bus_write(5'h18, 32'h08, 4'hF);
        bus_read(5'h18, rd);
        check("level_reset", rd & 32'h8, 32'h8);
        check("level_irq", 32'(irq_o), 32'h1);
        gpio_i[3] = 1'b1;
        repeat (4) tick();
        bus_write(5'h18, 32'h08, 4'hF);
        bus_read(5'h18, rd);
        check("level_clear", rd & 32'h8, 32'h0);
        check("level_irq_off", 32'(irq_o), 32'h0);

        // Set and clear on the same edge: set wins.
        bus_write(5'h10, 32'hFF, 4'hF);
        bus_write(5'h14, 32'hFF, 4'hF);
        bus_write(5'h18, 32'hFF, 4'hF);
        gpio_i[1] = 1'b1;
        tick();
        tick();
        bus_write(5'h18, 32'h02, 4'hF);
        bus_read(5'h18, rd);
        check("set_wins", rd & 32'h2, 32'h2);

        // Held strobe: ack every other cycle, each ack a separate toggle.
        wb_adr_i = 5'h1C; wb_dat_i = 32'h01; wb_sel_i = 4'hF;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (4) tick();
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: bus_write({3'($urandom_range(1, 7)), 2'($urandom)}, $urandom, 4'($urandom));
                1: bus_read({3'($urandom), 2'($urandom)}, rd);
                2: begin gpio_i = W'($urandom); tick(); end
                default: tick();
            endcase
        end

        // Reset in the middle of a write: no ack, no write, outputs reset at once.
        wb_adr_i = 5'h04; wb_dat_i = 32'h00; wb_sel_i = 4'hF;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("arst_gpio_o", 32'(gpio_o), 32'hA5);
        check("arst_dir", 32'(gpio_dir_o), 32'hFF);
        check("arst_ack", 32'(wb_ack_o), 32'h0);
        check("arst_irq", 32'(irq_o), 32'h0);
        check("arst_dat", wb_dat_o, 32'h0);
        @(posedge clock);
        #1;
        check("arst_hold_ack", 32'(wb_ack_o), 32'h0);
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        reset = 1'b0;
        model_reset();
        tick();
        check("post_rst_out", 32'(gpio_o), 32'hA5);
        bus_read(5'h04, rd);
        check("post_rst_rd_out", rd, 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
